// File: rtl/rng_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rng_arb_pkg
// Purpose : Shared types and helpers for the rng arbiter.
// Revision: 1.0
// ============================================================================
package rng_arb_pkg;

    localparam int BOUND_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DRAW = 2'd1,
        DONE = 2'd2
    } rng_arb_state_t;

    // Smallest 2^k-1 covering bound-1; bound 0 means the full 16-bit range.
    function automatic logic [BOUND_W-1:0] mask_for_bound(input logic [BOUND_W-1:0] bound);
        logic [BOUND_W-1:0] m;
        if (bound == '0) begin
            m = '1;
        end else begin
            m = bound - 16'd1;
            m = m | (m >> 1);
            m = m | (m >> 2);
            m = m | (m >> 4);
            m = m | (m >> 8);
        end
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rng_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module  : rng_arbiter_if
// Purpose : Request/result bundle between requesters and the rng arbiter.
// Revision: 1.0
// ============================================================================
interface rng_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [31:0]           rng_in;
    logic [NUM_REQ-1:0]    req_in;
    logic [NUM_REQ*16-1:0] bound_in;
    logic [15:0]           value_out;
    logic [NUM_REQ-1:0]    grant_out;
    logic                  valid_out;
    logic                  busy_out;

    modport slave (
        input  rng_in, req_in, bound_in,
        output value_out, grant_out, valid_out, busy_out
    );

    modport master (
        output rng_in, req_in, bound_in,
        input  value_out, grant_out, valid_out, busy_out
    );
endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rr_arbiter
// Purpose : Combinational round-robin picker, search starts after last.
// Revision: 1.0
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] req,
    input  wire logic [IDX_W-1:0]   last,
    output logic      [NUM_REQ-1:0] grant,
    output logic      [IDX_W-1:0]   idx,
    output logic                    any
);
    always_comb begin
        int j;
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = (int'(last) + i) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                grant[j] = 1'b1;
                idx      = IDX_W'(j);
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/rng_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : rng_arbiter
// Purpose : Round-robin sharing of one rng with masked rejection sampling.
// Revision: 1.0
// ============================================================================
module rng_arbiter
    import rng_arb_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int GAP       = 2,
    parameter int MAX_TRIES = 4
) (
    input  wire logic     clk_in,
    input  wire logic     rst_in,
    rng_arbiter_if.slave  bus
);
    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
    localparam int TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    rng_arb_state_t       state, state_nx;
    logic [IDX_W-1:0]     r_winner, r_last;
    logic [BOUND_W-1:0]   r_bound, r_mask, r_value;
    logic [GAP_W-1:0]     r_gap;
    logic [TRY_W-1:0]     r_tries;

    logic [NUM_REQ-1:0]   w_pick;
    logic [IDX_W-1:0]     w_idx;
    logic                 w_any;
    logic [BOUND_W-1:0]   w_bound_sel, w_sample;
    logic                 w_sample_edge, w_accept, w_last_try;
    logic [15:0]          w_unused_rng;

    assign w_unused_rng = bus.rng_in[31:16];

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (bus.req_in),
        .last  (r_last),
        .grant (w_pick),
        .idx   (w_idx),
        .any   (w_any)
    );

    always_comb begin
        w_bound_sel   = bus.bound_in[int'(w_idx)*BOUND_W +: BOUND_W];
        w_sample      = bus.rng_in[15:0] & r_mask;
        w_sample_edge = (state == DRAW) && (r_gap == '0);
        w_accept      = (r_bound == '0) || (w_sample < r_bound);
        w_last_try    = (r_tries == TRY_W'(MAX_TRIES - 1));
    end

    always_comb begin
        state_nx      = state;
        bus.valid_out = 1'b0;
        bus.grant_out = '0;
        bus.busy_out  = (state != IDLE);
        bus.value_out = r_value;
        case (state)
            IDLE: if (w_any) state_nx = DRAW;
            DRAW: if (w_sample_edge && (w_accept || w_last_try)) state_nx = DONE;
            DONE: begin
                state_nx                = IDLE;
                bus.valid_out           = 1'b1;
                bus.grant_out[r_winner] = 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state    <= IDLE;
            r_last   <= IDX_W'(NUM_REQ - 1);
            r_winner <= '0;
            r_bound  <= '0;
            r_mask   <= '0;
            r_value  <= '0;
            r_gap    <= '0;
            r_tries  <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (w_any) begin
                    r_winner <= w_idx;
                    r_bound  <= w_bound_sel;
                    r_mask   <= mask_for_bound(w_bound_sel);
                    r_gap    <= GAP_W'(GAP - 1);
                    r_tries  <= '0;
                end
                DRAW: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end else if (w_accept) begin
                        r_value <= w_sample;
                    end else if (w_last_try) begin
                        // mask < 2*bound keeps the fallback inside [0, bound)
                        r_value <= w_sample - r_bound;
                    end else begin
                        r_gap   <= GAP_W'(GAP - 1);
                        r_tries <= r_tries + 1'b1;
                    end
                end
                DONE: r_last <= r_winner;
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire
